// File: rtl/conv_tile_sched_if.sv
// Memory-port bundle between the tile scheduler (master) and the memory system (slave).
// Single outstanding transaction: request/attributes held until mem_gnt, reads complete on mem_rvalid.
interface conv_tile_sched_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/conv_tile_sched.sv
// Tile scheduler for a Winograd F(2x2,3x3) datapath: loads 3x3 weights and a 4x4 input tile,
// launches the datapath, then writes back 4 outputs (or one 2x2 max-pooled value) with optional ReLU.
module conv_tile_sched #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              skip_w,
    input  logic              relu_en,
    input  logic              pool_en,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [15:0]       row_stride,
    output logic              busy,
    output logic              done,
    conv_tile_sched_if.master mem,
    output logic              w_wr,
    output logic              x_wr,
    output logic [3:0]        ld_idx,
    output logic [31:0]       ld_data,
    output logic              calc_start,
    input  logic              calc_done,
    input  logic [31:0]       y0,
    input  logic [31:0]       y1,
    input  logic [31:0]       y2,
    input  logic [31:0]       y3
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_X,
        ST_CALC,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q;
    logic              wait_q;
    logic              launched_q;
    logic              relu_q, pool_q;
    logic [ADDR_W-1:0] w_base_q, in_base_q, out_base_q;
    logic [15:0]       stride_q;
    logic [31:0]       y_q [4];

    logic              rd_accept;
    logic [ADDR_W-1:0] x_word;
    logic [31:0]       y_in   [4];
    logic [31:0]       y_relu [4];
    logic [31:0]       y_max;

    // ReLU is applied before the signed max so pooling sees clamped values
    always_comb begin
        y_in[0] = y0;
        y_in[1] = y1;
        y_in[2] = y2;
        y_in[3] = y3;
        for (int unsigned i = 0; i < 4; i++) begin
            y_relu[i] = (relu_q && y_in[i][31]) ? '0 : y_in[i];
        end
        y_max = y_relu[0];
        for (int unsigned i = 1; i < 4; i++) begin
            if ($signed(y_relu[i]) > $signed(y_max)) y_max = y_relu[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        busy           = (state_q != ST_IDLE);
        done           = 1'b0;
        calc_start     = 1'b0;
        rd_accept      = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        x_word         = ADDR_W'(idx_q[3:2]) * ADDR_W'(stride_q) + ADDR_W'(idx_q[1:0]);
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = skip_w ? ST_LOAD_X : ST_LOAD_W;
            end
            ST_LOAD_W: begin
                mem.mem_req  = !wait_q;
                mem.mem_addr = w_base_q + (ADDR_W'(idx_q) << 2);
                rd_accept    = wait_q && mem.mem_rvalid;
                if (rd_accept && idx_q == 4'd8) state_d = ST_LOAD_X;
            end
            ST_LOAD_X: begin
                mem.mem_req  = !wait_q;
                mem.mem_addr = in_base_q + (x_word << 2);
                rd_accept    = wait_q && mem.mem_rvalid;
                if (rd_accept && idx_q == 4'd15) state_d = ST_CALC;
            end
            ST_CALC: begin
                calc_start = !launched_q;
                if (calc_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = out_base_q + (ADDR_W'(idx_q) << 2);
                mem.mem_wdata = y_q[idx_q[1:0]];
                if (mem.mem_gnt && (pool_q || idx_q == 4'd3)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            wait_q     <= 1'b0;
            launched_q <= 1'b0;
            relu_q     <= 1'b0;
            pool_q     <= 1'b0;
            w_base_q   <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            stride_q   <= '0;
            w_wr       <= 1'b0;
            x_wr       <= 1'b0;
            ld_idx     <= '0;
            ld_data    <= '0;
            for (int unsigned i = 0; i < 4; i++) y_q[i] <= '0;
        end else begin
            w_wr <= 1'b0;
            x_wr <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        relu_q     <= relu_en;
                        pool_q     <= pool_en;
                        w_base_q   <= w_base;
                        in_base_q  <= in_base;
                        out_base_q <= out_base;
                        stride_q   <= row_stride;
                        idx_q      <= '0;
                        wait_q     <= 1'b0;
                        launched_q <= 1'b0;
                    end
                end
                ST_LOAD_W, ST_LOAD_X: begin
                    if (mem.mem_req && mem.mem_gnt) wait_q <= 1'b1;
                    // Index wraps to 0 after the last weight (8) and the last tile word (15)
                    if (rd_accept) begin
                        wait_q  <= 1'b0;
                        ld_idx  <= idx_q;
                        ld_data <= mem.mem_rdata;
                        w_wr    <= (state_q == ST_LOAD_W);
                        x_wr    <= (state_q == ST_LOAD_X);
                        idx_q   <= (state_q == ST_LOAD_W && idx_q == 4'd8) ? '0 : idx_q + 4'd1;
                    end
                end
                ST_CALC: begin
                    launched_q <= 1'b1;
                    if (calc_done) begin
                        for (int unsigned i = 0; i < 4; i++) y_q[i] <= y_relu[i];
                        if (pool_q) y_q[0] <= y_max;
                    end
                end
                ST_WRITE: begin
                    if (mem.mem_gnt) idx_q <= idx_q + 4'd1;
                end
                ST_DONE: begin
                    idx_q      <= '0;
                    launched_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_sched.sv
// Self-checking bench for conv_tile_sched: a transaction-level model predicts every memory
// request and register load; a compare process checks the DUT against it each cycle.
module tb_conv_tile_sched;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, skip_w, relu_en, pool_en;
    logic [31:0] w_base, in_base, out_base;
    logic [15:0] row_stride;
    logic        busy, done, w_wr, x_wr, calc_start, calc_done;
    logic [3:0]  ld_idx;
    logic [31:0] ld_data, y0, y1, y2, y3;

    conv_tile_sched_if #(.ADDR_W(ADDR_W)) m ();

    conv_tile_sched #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .skip_w(skip_w),
        .relu_en(relu_en), .pool_en(pool_en),
        .w_base(w_base), .in_base(in_base), .out_base(out_base),
        .row_stride(row_stride), .busy(busy), .done(done), .mem(m),
        .w_wr(w_wr), .x_wr(x_wr), .ld_idx(ld_idx), .ld_data(ld_data),
        .calc_start(calc_start), .calc_done(calc_done),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } xact_t;
    typedef struct { logic is_x; logic [3:0] idx; logic [31:0] data; } ld_t;

    xact_t exp_req[$];
    xact_t act_log[$];
    ld_t   exp_ld[$];
    int    checks = 0, errors = 0;
    int    calc_cnt = 0, done_cnt = 0;
    int    gnt_delay = 0;
    logic  stale_rv = 1'b0;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model: grant after gnt_delay waiting cycles, read data one cycle after grant
    initial begin
        logic        pend, pend_we;
        logic [31:0] pend_addr;
        int          wait_cnt;
        pend = 1'b0; pend_we = 1'b0; pend_addr = '0; wait_cnt = 0;
        m.mem_gnt = 1'b0; m.mem_rvalid = 1'b0; m.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            m.mem_gnt    = 1'b0;
            m.mem_rvalid = 1'b0;
            if (rst) begin
                pend = 1'b0; wait_cnt = 0;
                continue;
            end
            if (pend) begin
                m.mem_rvalid = !pend_we;
                m.mem_rdata  = rd_fn(pend_addr);
                pend = 1'b0;
            end else if (stale_rv) begin
                m.mem_rvalid = 1'b1;
                m.mem_rdata  = 32'hDEAD_BEEF;
            end
            if (m.mem_req) begin
                if (wait_cnt >= gnt_delay) begin
                    m.mem_gnt = 1'b1;
                    pend = 1'b1; pend_we = m.mem_we; pend_addr = m.mem_addr;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Compare process
    initial begin
        logic        prev_wait;
        logic [31:0] prev_addr;
        xact_t       t, a;
        ld_t         l;
        prev_wait = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wait = 1'b0;
                continue;
            end
            if (prev_wait) begin
                chk("req_hold", {31'b0, m.mem_req}, 1);
                chk("addr_hold", m.mem_addr, prev_addr);
            end
            prev_wait = m.mem_req && !m.mem_gnt;
            prev_addr = m.mem_addr;
            if (m.mem_req && m.mem_gnt) begin
                a.addr = m.mem_addr; a.we = m.mem_we; a.data = m.mem_wdata;
                act_log.push_back(a);
                chk("req_expected", {31'b0, exp_req.size() != 0}, 1);
                if (exp_req.size() != 0) begin
                    t = exp_req.pop_front();
                    chk("req_addr", m.mem_addr, t.addr);
                    chk("req_we", {31'b0, m.mem_we}, {31'b0, t.we});
                    if (t.we) chk("req_wdata", m.mem_wdata, t.data);
                end
            end
            if (w_wr || x_wr) begin
                chk("ld_expected", {31'b0, exp_ld.size() != 0}, 1);
                if (exp_ld.size() != 0) begin
                    l = exp_ld.pop_front();
                    chk("ld_kind", {30'b0, w_wr, x_wr}, l.is_x ? 32'd1 : 32'd2);
                    chk("ld_idx", {28'b0, ld_idx}, {28'b0, l.idx});
                    chk("ld_data", ld_data, l.data);
                end
            end
            if (calc_start) calc_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic model_tile(input logic sk, rl, pl, input logic [31:0] wb, ib, ob,
                              input logic [15:0] st, input int ya, yb, yc, yd);
        int    yv[4];
        int    best;
        xact_t t;
        ld_t   l;
        t.we = 1'b0; t.data = '0;
        if (!sk) begin
            for (int i = 0; i < 9; i++) begin
                t.addr = wb + 32'(4 * i);
                exp_req.push_back(t);
                l.is_x = 1'b0; l.idx = 4'(i); l.data = rd_fn(t.addr);
                exp_ld.push_back(l);
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t.addr = ib + 32'(4 * (r * int'(st) + c));
                exp_req.push_back(t);
                l.is_x = 1'b1; l.idx = 4'(4 * r + c); l.data = rd_fn(t.addr);
                exp_ld.push_back(l);
            end
        end
        yv[0] = ya; yv[1] = yb; yv[2] = yc; yv[3] = yd;
        for (int i = 0; i < 4; i++) if (rl && yv[i] < 0) yv[i] = 0;
        t.we = 1'b1;
        if (pl) begin
            best = yv[0];
            for (int i = 1; i < 4; i++) if (yv[i] > best) best = yv[i];
            t.addr = ob; t.data = 32'(best);
            exp_req.push_back(t);
        end else begin
            for (int j = 0; j < 4; j++) begin
                t.addr = ob + 32'(4 * j); t.data = 32'(yv[j]);
                exp_req.push_back(t);
            end
        end
    endtask

    task automatic kick(input logic sk, rl, pl, input logic [31:0] wb, ib, ob, input logic [15:0] st);
        @(negedge clk);
        skip_w = sk; relu_en = rl; pool_en = pl;
        w_base = wb; in_base = ib; out_base = ob; row_stride = st;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_tile(input logic sk, rl, pl, input logic [31:0] wb, ib, ob,
                            input logic [15:0] st, input int ya, yb, yc, yd,
                            input int gd, input logic poke);
        int c0, d0, n;
        gnt_delay = gd;
        act_log.delete();
        c0 = calc_cnt; d0 = done_cnt;
        model_tile(sk, rl, pl, wb, ib, ob, st, ya, yb, yc, yd);
        kick(sk, rl, pl, wb, ib, ob, st);
        if (poke) begin
            n = 0;
            while (!x_wr && n < 2000) begin @(negedge clk); n++; end
            chk("poke_x_wr_seen", {31'b0, x_wr}, 1);
            start = 1'b1; skip_w = 1'b0; w_base = 32'hBAD0; in_base = 32'hBAD4; calc_done = 1'b1;
            @(negedge clk);
            start = 1'b0; calc_done = 1'b0;
        end
        n = 0;
        while (!calc_start && n < 3000) begin @(negedge clk); n++; end
        chk("calc_start_seen", {31'b0, calc_start}, 1);
        repeat (2) @(negedge clk);
        y0 = 32'(ya); y1 = 32'(yb); y2 = 32'(yc); y3 = 32'(yd);
        calc_done = 1'b1;
        @(negedge clk);
        calc_done = 1'b0;
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        chk("done_seen", {31'b0, done}, 1);
        @(negedge clk);
        chk("busy_after_done", {31'b0, busy}, 0);
        chk("done_one_cycle", {31'b0, done}, 0);
        chk("req_left", exp_req.size(), 0);
        chk("ld_left", exp_ld.size(), 0);
        chk("calc_start_count", calc_cnt - c0, 1);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        logic [31:0] tile_lit [16];
        logic [31:0] wr_lit [4];
        int n;
        tile_lit = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h220, 32'h224, 32'h228, 32'h22C,
                     32'h240, 32'h244, 32'h248, 32'h24C, 32'h260, 32'h264, 32'h268, 32'h26C};
        wr_lit   = '{32'd5, 32'd0, 32'd7, 32'd0};
        rst = 1'b1; start = 1'b0; skip_w = 1'b0; relu_en = 1'b0; pool_en = 1'b0;
        w_base = '0; in_base = '0; out_base = '0; row_stride = '0;
        calc_done = 1'b0; y0 = '0; y1 = '0; y2 = '0; y3 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem_req", {31'b0, m.mem_req}, 0);
        chk("rst_mem_addr", m.mem_addr, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_calc_start", {31'b0, calc_start}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Weights + tile, ReLU only
        run_tile(1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'h400, 16'd8, 5, -3, 7, -1, 0, 1'b0);
        chk("A_xact_count", act_log.size(), 29);
        if (act_log.size() == 29) begin
            chk("A_w0_addr", act_log[0].addr, 32'h100);
            chk("A_w8_addr", act_log[8].addr, 32'h120);
            for (int k = 0; k < 16; k++) chk("A_tile_addr", act_log[9 + k].addr, tile_lit[k]);
            for (int j = 0; j < 4; j++) begin
                chk("A_wr_addr", act_log[25 + j].addr, 32'h400 + 32'(4 * j));
                chk("A_wr_data", act_log[25 + j].data, wr_lit[j]);
            end
        end

        // Reuse weights, pool only
        run_tile(1'b1, 1'b0, 1'b1, 32'h100, 32'h1000, 32'h800, 16'd3, 5, -3, 7, -1, 0, 1'b0);
        chk("B_xact_count", act_log.size(), 17);
        if (act_log.size() == 17) begin
            chk("B_first_addr", act_log[0].addr, 32'h1000);
            chk("B_pool_addr", act_log[16].addr, 32'h800);
            chk("B_pool_data", act_log[16].data, 32'd7);
        end

        // All-negative with ReLU+pool, slow grants, start/calc_done poked while busy
        run_tile(1'b0, 1'b1, 1'b1, 32'h2000, 32'h2100, 32'h2200, 16'd16, -9, -4, -6, -8, 5, 1'b1);
        chk("C_xact_count", act_log.size(), 26);
        if (act_log.size() == 26) chk("C_pool_data", act_log[25].data, 32'd0);

        // Reset mid-LOAD_X while tile word 7 is in flight
        gnt_delay = 0;
        model_tile(1'b0, 1'b0, 1'b0, 32'h500, 32'h600, 32'h700, 16'd4, 1, 2, 3, 4);
        kick(1'b0, 1'b0, 1'b0, 32'h500, 32'h600, 32'h700, 16'd4);
        n = 0;
        while (!(x_wr && ld_idx == 4'd6) && n < 500) begin @(negedge clk); n++; end
        chk("x6_seen", {28'b0, ld_idx}, 6);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_done", {31'b0, done}, 0);
        chk("mid_rst_req", {31'b0, m.mem_req}, 0);
        chk("mid_rst_we", {31'b0, m.mem_we}, 0);
        chk("mid_rst_addr", m.mem_addr, 0);
        chk("mid_rst_wdata", m.mem_wdata, 0);
        chk("mid_rst_wr", {30'b0, w_wr, x_wr}, 0);
        chk("mid_rst_ld_idx", {28'b0, ld_idx}, 0);
        chk("mid_rst_ld_data", ld_data, 0);
        chk("mid_rst_calc_start", {31'b0, calc_start}, 0);
        exp_req.delete();
        exp_ld.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stale_rv = 1'b1;
        @(negedge clk);
        stale_rv = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_busy", {31'b0, busy}, 0);
        chk("stale_ld_data", ld_data, 0);

        // Fresh tile after reset restarts at weight index 0
        run_tile(1'b0, 1'b0, 1'b0, 32'h3000, 32'h3100, 32'h3200, 16'd1, 1, -2, 3, -4, 0, 1'b0);
        chk("D_xact_count", act_log.size(), 29);
        if (act_log.size() == 29) begin
            chk("D_first_addr", act_log[0].addr, 32'h3000);
            chk("D_wr1_data", act_log[26].data, 32'hFFFF_FFFE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
